// File: rtl/redun_mont_pkg.sv
// Shared types for the redundant-form Montgomery squarer and its sequencer.
// Digits carry one spare bit so partial carries can stay unresolved.
package redun_mont_pkg;

    localparam int NUM_DIG = 4;
    localparam int DIG_W   = 16;
    localparam int VAL_W   = NUM_DIG * DIG_W;

    typedef logic [NUM_DIG-1:0][DIG_W:0] redun0_t;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        LOAD,
        RUN,
        DONE
    } vdf_ctrl_state_t;

    function automatic redun0_t to_redun(input logic [VAL_W-1:0] v);
        redun0_t r;
        for (int i = 0; i < NUM_DIG; i++) begin
            r[i] = {1'b0, v[i*DIG_W +: DIG_W]};
        end
        return r;
    endfunction

    // Carries are resolved modulo 2**VAL_W.
    function automatic logic [VAL_W-1:0] from_redun(input redun0_t r);
        logic [VAL_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            acc = acc + (VAL_W'(r[i]) << (i * DIG_W));
        end
        return acc;
    endfunction

endpackage

// File: rtl/vdf_sq_ctrl.sv
// Job sequencer for the redundant Montgomery squarer: seed, count T
// squarings, emit checkpoints, hand back the T-th result.
module vdf_sq_ctrl
    import redun_mont_pkg::*;
#(
    parameter int CNT_W    = 64,
    parameter int RST_HOLD = 16,
    parameter int CHK_LOG2 = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start_val,
    output logic             o_start_rdy,
    input  redun0_t          i_start_sq,
    input  logic [CNT_W-1:0] i_start_t,
    input  logic             i_abort,
    output redun0_t          o_res,
    output logic             o_res_val,
    input  logic             i_res_rdy,
    output redun0_t          o_chk,
    output logic             o_chk_val,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_iter,
    output logic             o_mont_rst,
    output redun0_t          o_mont_sq,
    output logic             o_mont_val,
    input  redun0_t          i_mont_mul,
    input  logic             i_mont_val
);

    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD - 1);

    vdf_ctrl_state_t  state;
    logic [HW-1:0]    hold;
    redun0_t          seed;
    logic [CNT_W-1:0] t_cnt;
    logic [CNT_W-1:0] nxt;
    logic             chk_hit;
    logic             accept;

    assign nxt     = o_iter + CNT_W'(1);
    assign chk_hit = (nxt[CHK_LOG2-1:0] == '0);
    assign accept  = o_start_rdy & i_start_val & ~i_abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold        <= '0;
            seed        <= '0;
            t_cnt       <= '0;
            o_start_rdy <= 1'b0;
            o_res       <= '0;
            o_res_val   <= 1'b0;
            o_chk       <= '0;
            o_chk_val   <= 1'b0;
            o_busy      <= 1'b0;
            o_iter      <= '0;
            o_mont_rst  <= 1'b1;
            o_mont_sq   <= '0;
            o_mont_val  <= 1'b0;
        end else begin
            o_chk_val <= 1'b0;
            if (i_abort && state != IDLE) begin
                // Abort also drops a pending result or in-flight sample.
                state       <= IDLE;
                o_start_rdy <= 1'b1;
                o_res_val   <= 1'b0;
                o_busy      <= 1'b0;
                o_mont_rst  <= 1'b1;
                o_mont_sq   <= '0;
                o_mont_val  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept) begin
                            seed        <= i_start_sq;
                            t_cnt       <= i_start_t;
                            o_iter      <= '0;
                            o_start_rdy <= 1'b0;
                            o_busy      <= 1'b1;
                            if (i_start_t == '0) begin
                                state     <= DONE;
                                o_res     <= i_start_sq;
                                o_res_val <= 1'b1;
                            end else begin
                                state <= RESET;
                                hold  <= HOLD_INIT;
                            end
                        end else begin
                            o_start_rdy <= 1'b1;
                        end
                    end
                    RESET: begin
                        if (hold == '0) begin
                            state      <= LOAD;
                            o_mont_rst <= 1'b0;
                            o_mont_val <= 1'b1;
                            o_mont_sq  <= seed;
                        end else begin
                            hold <= hold - HW'(1);
                        end
                    end
                    LOAD: begin
                        state      <= RUN;
                        o_mont_val <= 1'b0;
                        o_mont_sq  <= '0;
                    end
                    RUN: begin
                        if (i_mont_val) begin
                            o_iter <= nxt;
                            if (nxt == t_cnt) begin
                                state      <= DONE;
                                o_res      <= i_mont_mul;
                                o_res_val  <= 1'b1;
                                o_mont_rst <= 1'b1;
                            end else if (chk_hit) begin
                                o_chk     <= i_mont_mul;
                                o_chk_val <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (i_res_rdy) begin
                            state       <= IDLE;
                            o_res_val   <= 1'b0;
                            o_busy      <= 1'b0;
                            o_start_rdy <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
